// File: rtl/task_clk_sequencer.sv
// ---------------------------------------------------------------------------
// task_clk_sequencer
//
// Run-control sequencer for a gated task clock. Drives the clock-enable of
// the task clock gate (BUFGCE CE) and counts every enabled task-clock cycle.
// A host issues commands over a valid/ready handshake: CLEAR the counter,
// RUN freely, STEP N cycles, or RUN_TO an absolute cycle count. A running
// operation can be aborted with halt_req. Every finished command produces
// a one-cycle done pulse with a status code.
//
// Optional build macro: EXT_TRIG_HALT_EN
//   When defined, adds input trig_in. A trigger stops a running operation
//   with status 3. Priority: natural completion > halt_req > trig_in.
//
// Ports:
//   sys_clk      in   system clock, all logic on the rising edge
//   sys_reset_n  in   asynchronous active-low reset
//   cmd_valid    in   command present
//   cmd_ready    out  sequencer idle and able to accept a command
//   cmd_op       in   0=CLEAR 1=RUN 2=STEP 3=RUN_TO
//   cmd_arg      in   STEP: cycle count N, RUN_TO: absolute target
//   halt_req     in   abort the current RUN/STEP/RUN_TO
//   trig_in      in   (EXT_TRIG_HALT_EN only) external trigger halt
//   clk_en       out  registered enable for the task clock gate
//   running      out  high while in RUN/STEP/RUN_TO
//   cycle_count  out  enabled cycles since reset/CLEAR (wraps)
//   done         out  one-cycle completion pulse
//   done_status  out  0=complete 1=aborted 2=target already reached 3=trigger
// ---------------------------------------------------------------------------
module task_clk_sequencer #(
  parameter int CW = 32
) (
  input  logic          sys_clk,
  input  logic          sys_reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_arg,
  input  logic          halt_req,
`ifdef EXT_TRIG_HALT_EN
  input  logic          trig_in,
`endif
  output logic          clk_en,
  output logic          running,
  output logic [CW-1:0] cycle_count,
  output logic          done,
  output logic [1:0]    done_status
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FREE = 2'd1,
    S_STEP = 2'd2,
    S_TOGO = 2'd3
  } state_t;

  localparam logic [1:0] OP_CLEAR  = 2'd0;
  localparam logic [1:0] OP_RUN    = 2'd1;
  localparam logic [1:0] OP_STEP   = 2'd2;
  localparam logic [1:0] OP_RUN_TO = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ABORT   = 2'd1;
  localparam logic [1:0] ST_REACHED = 2'd2;
  localparam logic [1:0] ST_TRIG    = 2'd3;

  state_t        state_q;
  logic          clk_en_q;
  logic          running_q;
  logic          cmd_ready_q;
  logic          done_q;
  logic [1:0]    status_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] remaining_q;
  logic [CW-1:0] target_q;

  logic [CW-1:0] count_inc;
  logic          natural_end;
  logic          fin_d;
  logic [1:0]    fin_status_d;
  logic          trig;

`ifdef EXT_TRIG_HALT_EN
  assign trig = trig_in;
`else
  assign trig = 1'b0;
`endif

  assign count_inc = count_q + CW'(1);

  // The edge that counts the last enabled cycle of a STEP or RUN_TO.
  // TOGO compares the post-increment value so the counter never passes
  // the target, including when it wraps through 2^CW on the way.
  assign natural_end = ((state_q == S_STEP) && (remaining_q == CW'(1))) ||
                       ((state_q == S_TOGO) && (count_inc == target_q));

  // Decide whether this edge finishes a command and with which status.
  always_comb begin
    fin_d        = 1'b0;
    fin_status_d = ST_OK;
    if (state_q == S_IDLE) begin
      if (cmd_valid) begin
        if (cmd_op == OP_CLEAR) begin
          fin_d = 1'b1;
        end else if ((cmd_op == OP_STEP) && (cmd_arg == '0)) begin
          fin_d = 1'b1;
        end else if ((cmd_op == OP_RUN_TO) && (cmd_arg == count_q)) begin
          fin_d        = 1'b1;
          fin_status_d = ST_REACHED;
        end
      end
    end else begin
      if (natural_end) begin
        fin_d = 1'b1;
      end else if (halt_req) begin
        fin_d        = 1'b1;
        fin_status_d = ST_ABORT;
      end else if (trig) begin
        fin_d        = 1'b1;
        fin_status_d = ST_TRIG;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q     <= S_IDLE;
      clk_en_q    <= 1'b0;
      running_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      status_q    <= ST_OK;
      count_q     <= '0;
      remaining_q <= '0;
      target_q    <= '0;
    end else begin
      done_q <= 1'b0;
      // An enabled cycle is always counted, even on a halting edge.
      if (clk_en_q) count_q <= count_inc;
      if (state_q == S_STEP) remaining_q <= remaining_q - CW'(1);

      if (fin_d) begin
        state_q     <= S_IDLE;
        clk_en_q    <= 1'b0;
        running_q   <= 1'b0;
        cmd_ready_q <= 1'b1;
        done_q      <= 1'b1;
        status_q    <= fin_status_d;
        // fin_d in IDLE implies an accepted command; clk_en is low in IDLE
        // so the clear cannot collide with an increment.
        if ((state_q == S_IDLE) && (cmd_op == OP_CLEAR)) count_q <= '0;
      end else if ((state_q == S_IDLE) && cmd_valid) begin
        // Only commands that actually run reach here; CLEAR always finishes.
        case (cmd_op)
          OP_RUN: begin
            state_q <= S_FREE;
          end
          OP_STEP: begin
            state_q     <= S_STEP;
            remaining_q <= cmd_arg;
          end
          OP_RUN_TO: begin
            state_q  <= S_TOGO;
            target_q <= cmd_arg;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
        if (cmd_op != OP_CLEAR) begin
          clk_en_q    <= 1'b1;
          running_q   <= 1'b1;
          cmd_ready_q <= 1'b0;
        end
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign clk_en      = clk_en_q;
  assign running     = running_q;
  assign cycle_count = count_q;
  assign done        = done_q;
  assign done_status = status_q;

endmodule

// File: tb/tb_task_clk_sequencer.sv
module tb_task_clk_sequencer;

  localparam int CW = 4;
  localparam int MOD = 1 << CW;

  logic          sys_clk;
  logic          sys_reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_arg;
  logic          halt_req;
`ifdef EXT_TRIG_HALT_EN
  logic          trig_in;
`endif
  logic          clk_en;
  logic          running;
  logic [CW-1:0] cycle_count;
  logic          done;
  logic [1:0]    done_status;

  int pass_count  = 0;
  int check_count = 0;
  int fail_count  = 0;
  int model_count = 0;   // reference counter value, 0..MOD-1

  task_clk_sequencer #(.CW(CW)) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .halt_req    (halt_req),
`ifdef EXT_TRIG_HALT_EN
    .trig_in     (trig_in),
`endif
    .clk_en      (clk_en),
    .running     (running),
    .cycle_count (cycle_count),
    .done        (done),
    .done_status (done_status)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: how many enabled cycles a command yields and its status.
  // h/t: abort after that many enabled cycles (0 = never).
  function automatic void model(input int op, input int arg, input int cnt,
                                input int h, input int t,
                                output int en, output int st);
    int nat;
    int ab;
    int ab_st;
    en = 0;
    st = 0;
    if (op == 0) return;
    if (op == 1) nat = -1;
    else if (op == 2) nat = arg;
    else begin
      nat = (arg - cnt + MOD) % MOD;
      if (nat == 0) begin
        st = 2;
        return;
      end
    end
    if (nat == 0) return;
    ab = 0;
    ab_st = 0;
    if (h > 0) begin
      ab = h;
      ab_st = 1;
    end
    if (t > 0 && (ab == 0 || t < ab)) begin
      ab = t;
      ab_st = 3;
    end
    if (nat >= 0 && (ab == 0 || nat <= ab)) begin
      en = nat;
      st = 0;
    end else begin
      en = ab;
      st = ab_st;
    end
  endfunction

  // Called at a sample point (1 time unit after a rising edge).
  task automatic run_cmd(input int op, input int arg, input int h, input int t);
    int exp_en;
    int exp_st;
    int en;
    int cyc;
    bit got_done;
    model(op, arg, model_count, h, t, exp_en, exp_st);
    chk("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_arg   = CW'(arg);
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    en = 0;
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 100) begin
      cyc++;
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (clk_en) begin
          chk("count_track", int'(cycle_count), (model_count + en) % MOD);
          en++;
          if (h > 0 && en == h) halt_req = 1'b1;
`ifdef EXT_TRIG_HALT_EN
          if (t > 0 && en == t) trig_in = 1'b1;
`endif
        end
        @(posedge sys_clk); #1;
        halt_req = 1'b0;
`ifdef EXT_TRIG_HALT_EN
        trig_in = 1'b0;
`endif
      end
    end
    chk("done_seen", int'(got_done), 1);
    chk("enabled_cycles", en, exp_en);
    chk("done_latency", cyc, exp_en + 1);
    chk("done_status", int'(done_status), exp_st);
    model_count = (op == 0) ? 0 : (model_count + exp_en) % MOD;
    chk("count_end", int'(cycle_count), model_count);
    chk("clk_en_end", int'(clk_en), 0);
    chk("running_end", int'(running), 0);
    chk("ready_with_done", int'(cmd_ready), 1);
    @(posedge sys_clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("status_held", int'(done_status), exp_st);
    $display("txn op=%0d arg=%0d halt=%0d trig=%0d enabled=%0d status=%0d count=%0d",
             op, arg, h, t, en, done_status, cycle_count);
  endtask

  initial begin
    int op;
    int arg;
    int h;
    int t;
    sys_reset_n = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 2'd0;
    cmd_arg     = '0;
    halt_req    = 1'b0;
`ifdef EXT_TRIG_HALT_EN
    trig_in     = 1'b0;
`endif
    #12;
    chk("rst_clk_en", int'(clk_en), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_status", int'(done_status), 0);
    chk("rst_count", int'(cycle_count), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    #10 sys_reset_n = 1'b1;
    @(posedge sys_clk); #1;

    // Directed sequence
    run_cmd(2, 5, 0, 0);    // STEP 5 -> count 5
    run_cmd(3, 12, 0, 0);   // RUN_TO 12 -> 7 cycles
    run_cmd(3, 12, 0, 0);   // already there -> status 2
    run_cmd(0, 0, 0, 0);    // CLEAR
    run_cmd(1, 0, 10, 0);   // RUN halted after 10 -> count 10, status 1

    // halt in IDLE has no effect
    halt_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk); #1;
      chk("idle_halt_done", int'(done), 0);
      chk("idle_halt_en", int'(clk_en), 0);
      chk("idle_halt_count", int'(cycle_count), model_count);
    end
    halt_req = 1'b0;
    $display("txn idle halt: done=%0d count=%0d", done, cycle_count);

    run_cmd(2, 4, 0, 0);    // count 14
    run_cmd(2, 3, 0, 0);    // wraps 15,0,1
    run_cmd(3, 0, 0, 0);    // RUN_TO 0 from 1 -> 15 cycles
    run_cmd(2, 4, 4, 0);    // halt on last counted edge -> status 0
    run_cmd(2, 0, 0, 0);    // STEP 0 -> immediate done

    // Randomized sequence
    for (int n = 0; n < 40; n++) begin
      op  = int'($urandom_range(0, 3));
      arg = int'($urandom_range(0, MOD - 1));
      h   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16)) : 0;
      t   = 0;
`ifdef EXT_TRIG_HALT_EN
      t   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16)) : 0;
`endif
      if (op == 1 && h == 0 && t == 0) h = int'($urandom_range(1, 20));
      run_cmd(op, arg, h, t);
    end

`ifdef EXT_TRIG_HALT_EN
    run_cmd(0, 0, 0, 0);
    run_cmd(1, 0, 0, 3);    // trigger after 3 -> status 3
    run_cmd(1, 0, 2, 2);    // halt and trigger together -> status 1
`endif

    // Asynchronous reset in the middle of a STEP
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_arg   = CW'(10);
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge sys_clk); #1;
    end
    chk("mid_step_en", int'(clk_en), 1);
    #2 sys_reset_n = 1'b0;
    #1;
    chk("async_rst_en", int'(clk_en), 0);
    chk("async_rst_count", int'(cycle_count), 0);
    chk("async_rst_ready", int'(cmd_ready), 1);
    chk("async_rst_running", int'(running), 0);
    $display("txn async reset mid-STEP: clk_en=%0d count=%0d ready=%0d",
             clk_en, cycle_count, cmd_ready);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    model_count = 0;
    @(posedge sys_clk); #1;
    run_cmd(2, 2, 0, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/task_clk_sequencer.md
Name: task_clk_sequencer

Overview:
Run-control sequencer that drives the clock-enable of the gated task clock (BUFGCE CE) and tracks elapsed task-clock cycles. Accepts host commands over a valid/ready interface: clear count, free-run, step N cycles, run until an absolute cycle count. Halts on request and reports completion with a status code. Sits between the host/VIO debug path and the clock-gating primitive.

Parameters:
CW, 32, width of cycle counter, step argument and target argument.

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  0=CLEAR, 1=RUN, 2=STEP, 3=RUN_TO
cmd_arg  input  CW  STEP: cycle count N; RUN_TO: absolute target; else ignored
halt_req  input  1  abort current RUN/STEP/RUN_TO, sampled each edge
clk_en  output  1  registered enable for task clock gate
running  output  1  high in RUN/STEP/RUN_TO states
cycle_count  output  CW  enabled cycles since reset/CLEAR
done  output  1  one-cycle completion pulse
done_status  output  2  0=complete, 1=aborted, 2=target already reached/passed, 3=trigger; valid with done, held until next done

Behaviour:
- Reset (async, sys_reset_n=0): state IDLE; clk_en=0, running=0, done=0, done_status=0, cycle_count=0, cmd_ready=1. Reset mid-operation drops clk_en immediately.
- States: IDLE, FREE, STEP, TOGO. cmd_ready = (state==IDLE). Accept = cmd_valid & cmd_ready at an edge.
- All outputs registered. clk_en high exactly during cycles in which cycle_count increments; cycle_count += 1 (mod 2^CW, wraps) at every edge where clk_en=1.
- CLEAR: cycle_count<=0 at accept edge; done pulses next cycle, status 0; stays IDLE.
- RUN: -> FREE; clk_en high from cycle after accept; exits only on halt_req (status 1).
- STEP N>0: -> STEP, remaining<=N; clk_en high for exactly N consecutive cycles starting cycle after accept. STEP N=0: no enabled cycles, done next cycle, status 0.
- RUN_TO T: T==cycle_count at accept -> no enabled cycles, done next cycle, status 2. Else -> TOGO; clk_en high until cycle_count==T (equality; wraps through 2^CW if T<count). cycle_count never passes T.
- Completion: at the edge where the last enabled cycle is counted, clk_en<=0, running<=0, state<=IDLE, done<=1, cmd_ready<=1, all for the next cycle.
- halt_req=1 at an edge in FREE/STEP/TOGO: that edge's enabled cycle still counted if clk_en was 1; then same completion timing, status 1. halt_req in IDLE ignored.
- halt_req on same edge as natural completion: complete wins, status 0.
- cmd_valid while not ready: held by requester, no effect.

Optional Feature:
Macro EXT_TRIG_HALT_EN. Defined: adds input trig_in (1 bit, sys_clk domain, from DUT). trig_in=1 at an edge in FREE/STEP/TOGO halts with completion timing of halt_req, status 3. Priority: natural completion > halt_req > trig_in. Undefined: no trig_in port; status 3 never produced.

Test Plan:
- Reset, STEP N=5 -> clk_en high exactly 5 cycles starting cycle after accept, cycle_count=5, done 1 cycle, status 0, cmd_ready back high with done.
- cycle_count=5, RUN_TO 12 -> 7 enabled cycles, count=12, status 0; then RUN_TO 12 -> 0 enabled cycles, done next cycle, status 2.
- RUN, halt_req pulse after 10 enabled cycles -> clk_en low next cycle, count=10, status 1; halt_req in IDLE -> no done.
- CW=4, count=14, STEP 3 -> count wraps 15,0,1; RUN_TO 0 from count 1 -> 15 enabled cycles, count=0.
- STEP 4 with halt_req on edge of 4th counted cycle -> count=4, status 0; sys_reset_n low mid-STEP -> clk_en=0 immediately, count=0, cmd_ready=1.
- EXT_TRIG_HALT_EN defined: RUN, trig_in high after 3 cycles -> count=3, status 3; trig_in and halt_req same edge -> status 1.
